// File: rtl/arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Optional build macro used by the top: ARB_PERF_CNT_EN (performance counters).
package arb_pkg;

    localparam int ADDRESS_BITS_DEF = 16;
    localparam int DATA_BITS_DEF    = 32;
    localparam int MAX_STARVE_DEF   = 4;
    localparam int STARVE_CNT_W     = 4;

    // Owner of the read response that returns one cycle after a grant
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } own_e;

endpackage

// File: rtl/arb_prio_grant.sv
// Two-way fixed-priority grant: data beats fetch unless fetch has been
// denied MAX_STARVE cycles in a row. Purely combinational.
module arb_prio_grant
    import arb_pkg::*;
#(
    parameter int MAX_STARVE = MAX_STARVE_DEF
) (
    input  logic                    fetch_req_i,
    input  logic                    data_req_i,
    input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
    input  logic                    block_i,      // suppress all grants (reset)
    output logic                    fetch_gnt_o,
    output logic                    data_gnt_o,
    output logic                    forced_o      // fetch won only because of starvation
);

    logic starved;

    assign starved = (starve_cnt_i == STARVE_CNT_W'(MAX_STARVE));

    // Grant decision
    always_comb begin
        fetch_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        forced_o    = 1'b0;
        if (!block_i) begin
            if (fetch_req_i && data_req_i) begin
                fetch_gnt_o = starved;
                data_gnt_o  = !starved;
                forced_o    = starved;
            end else begin
                fetch_gnt_o = fetch_req_i;
                data_gnt_o  = data_req_i;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch and
// load/store. One grant per cycle; read data returns the next cycle and is
// steered to the requester recorded in resp_own_q.
// Optional build macro: ARB_PERF_CNT_EN adds saturating performance counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int MAX_STARVE   = MAX_STARVE_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRESS_BITS-1:0] i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_BITS-1:0]    i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_BITS-1:0] d_addr,
    input  logic [DATA_BITS-1:0]    d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_BITS-1:0]    d_rdata,
    output logic                    m_en,
    output logic                    m_we,
    output logic [ADDRESS_BITS-1:0] m_addr,
    output logic [DATA_BITS-1:0]    m_wdata,
    input  logic [DATA_BITS-1:0]    m_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]             conflict_cnt,
    output logic [31:0]             i_stall_cnt,
    output logic [15:0]             starve_win_cnt
`endif
);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    own_e                    resp_own_q, resp_own_d;
    logic                    forced;

    arb_prio_grant #(.MAX_STARVE(MAX_STARVE)) u_grant (
        .fetch_req_i  (i_req),
        .data_req_i   (d_req),
        .starve_cnt_i (starve_cnt_q),
        .block_i      (reset),
        .fetch_gnt_o  (i_gnt),
        .data_gnt_o   (d_gnt),
        .forced_o     (forced)
    );

    // Memory port mux: idle port drives all zeros
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (i_gnt) begin
            m_addr = i_addr;
        end else if (d_gnt) begin
            m_addr = d_addr;
            if (d_we) m_wdata = d_wdata;
        end
    end

    // Starvation counter and response owner next state
    always_comb begin
        starve_cnt_d = '0;
        if (i_req && !i_gnt) begin
            if (starve_cnt_q == STARVE_CNT_W'(MAX_STARVE)) starve_cnt_d = starve_cnt_q;
            else                                          starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
        resp_own_d = OWN_NONE;
        if (i_gnt)              resp_own_d = OWN_INSTR;
        else if (d_gnt && !d_we) resp_own_d = OWN_DATA;
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            resp_own_q   <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_own_q   <= resp_own_d;
        end
    end

    // Response steering; reset also drops a response already in flight
    always_comb begin
        i_rvalid = (resp_own_q == OWN_INSTR) && !reset;
        d_rvalid = (resp_own_q == OWN_DATA)  && !reset;
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt   <= '0;
            i_stall_cnt    <= '0;
            starve_win_cnt <= '0;
        end else begin
            if (i_req && d_req && conflict_cnt != '1)  conflict_cnt   <= conflict_cnt + 32'd1;
            if (i_req && !i_gnt && i_stall_cnt != '1)  i_stall_cnt    <= i_stall_cnt + 32'd1;
            if (forced && starve_win_cnt != '1)        starve_win_cnt <= starve_win_cnt + 16'd1;
        end
    end
`endif

endmodule
